// File: rtl/prim_device_arbiter.sv
// prim_device_arbiter: round-robin arbiter/sequencer sharing one primitive_device between N_REQ requesters.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_i, sw_i         per-requester request level and switch code (slice i at [i*SW_W +: SW_W])
//   resp_valid_o        one-hot single-cycle completion strobe to the served requester
//   resp_data_o         captured device result (0 after a timeout)
//   resp_err_o          high with resp_valid_o when the job was aborted by the watchdog
//   dev_en_o, dev_sw_o  enable and latched switch code to the device
//   dev_done_i          done level from the device
//   dev_result_i        result from the device
//   busy_o              high whenever the sequencer is not idle
module prim_device_arbiter #(
    parameter int N_REQ   = 4,
    parameter int SW_W    = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*SW_W-1:0] sw_i,
    output logic [N_REQ-1:0]      resp_valid_o,
    output logic [DATA_W-1:0]     resp_data_o,
    output logic                  resp_err_o,
    output logic                  dev_en_o,
    output logic [SW_W-1:0]       dev_sw_o,
    input  logic                  dev_done_i,
    input  logic [DATA_W-1:0]     dev_result_i,
    output logic                  busy_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [SW_W-1:0]   sw_q, sw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [IW-1:0]     pick, cand;
    logic              found;

    // Cyclic search starting just after the last winner.
    always_comb begin
        pick  = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        sw_d    = sw_q;
        cnt_d   = '0;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found) begin
                win_d   = pick;
                ptr_d   = pick;
                sw_d    = sw_i[int'(pick)*SW_W +: SW_W];
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Done has priority over a watchdog expiry on the same edge.
                if (dev_done_i) begin
                    data_d  = dev_result_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = DRAIN;
            DRAIN:   state_d = dev_done_i ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign dev_en_o     = (state_q == RUN);
    assign busy_o       = (state_q != IDLE);
    assign dev_sw_o     = sw_q;
    assign resp_data_o  = data_q;
    assign resp_err_o   = (state_q == RESP) && err_q;
    assign resp_valid_o = (state_q == RESP) ? N_REQ'(1) << win_q : '0;
endmodule
